dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- Memory stage of the RISC-V core; sits directly downstream of the ALU.
- Takes the ALU result (effective address), rs2 data, funct3 and memren/memwren from control.
- Drives a variable-latency data memory through a req/gnt/rvalid handshake, performs byte/half/word alignment and load sign/zero extension, and stalls upstream stages until the access completes.
- Its load result feeds the writeback mux.

Parameters:
AWIDTH, 32, address width in bits
DWIDTH, 32, data width in bits (fixed at 32; byte enables are 4 bits)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
valid_i  input  1  instruction present in the stage this cycle
memren_i  input  1  load request from control
memwren_i  input  1  store request from control
funct3_i  input  3  RV32I load/store width/sign code
addr_i  input  AWIDTH  effective address (ALU result)
storedata_i  input  DWIDTH  rs2 store data, right-aligned
stall_o  output  1  hold upstream stages
done_o  output  1  one-cycle completion pulse
misalign_o  output  1  one-cycle misaligned/illegal-access pulse
loaddata_o  output  DWIDTH  extended load result, registered
dmem_req_o  output  1  memory request
dmem_we_o  output  1  memory write enable
dmem_addr_o  output  AWIDTH  word-aligned address
dmem_wdata_o  output  DWIDTH  lane-replicated write data
dmem_be_o  output  4  byte enables
dmem_gnt_i  input  1  memory accepted the request
dmem_rvalid_i  input  1  read data valid
dmem_rdata_i  input  DWIDTH  read data

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset value of every output is 0. FSM state is IDLE.
- FSM states: IDLE, REQ, WAIT, RESP, ERR.
- IDLE, accept condition: `valid_i` && (`memren_i` || `memwren_i`). If both are set, the access is a store. `valid_i` with neither set is ignored and `stall_o` stays 0.
- IDLE, on accept:
  - Latch address, `funct3`, we, shifted wdata and be.
  - Misaligned or illegal access goes to ERR: halfword with addr[0]=1; word with addr[1:0]≠0; load funct3 ∈ {3,6,7}; store funct3 ≥ 3.
  - Otherwise go to REQ.
- REQ:
  - `dmem_req_o`=1. `dmem_we_o`/`dmem_addr_o`/`dmem_wdata_o`/`dmem_be_o` are held stable until `dmem_gnt_i`.
  - On gnt, a store goes to RESP and a load goes to WAIT.
- WAIT:
  - `dmem_rvalid_i` is sampled only in this state; memory guarantees rvalid ≥1 cycle after gnt.
  - On rvalid, register the extracted data into `loaddata_o` and go to RESP.
- RESP: `done_o`=1 for one cycle, then IDLE.
- ERR: `misalign_o`=1 and `done_o`=1 for one cycle, no memory request, then IDLE.
- `dmem_*` outputs are 0 outside REQ.
- `dmem_addr_o` = {addr[AWIDTH-1:2], 2'b00}.
- `stall_o` (combinational) = 1 in REQ/WAIT, and in IDLE when the accept condition is true. It is 0 in RESP/ERR so upstream advances in the done cycle.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - SW: wdata=sd, be=4'b1111.
- Load extraction from `dmem_rdata_i`:
  - Byte lane addr[1:0]; LB sign-extend, LBU zero-extend.
  - Half lane addr[1]; LH sign-extend, LHU zero-extend.
  - LW passes the word through.
- `loaddata_o` holds its value until the next load completes. Stores and errors do not modify it.
- Latency with accept in cycle N:
  - REQ from N+1.
  - Store with immediate gnt: `done_o` in N+2.
  - Load with immediate gnt and rvalid one cycle later: `done_o` in N+3.
- Inputs other than `dmem_*` are ignored outside IDLE.
- Reset asserted mid-transaction: the access is abandoned and `dmem_req_o`/`stall_o`/`done_o` drop immediately. Any late rvalid after reset is ignored, since IDLE does not sample rvalid.

Test Plan:
- SW addr 0x01000008, data 0xDEADBEEF, gnt delayed 2 cycles -> `dmem_req_o` high 3 cycles with addr 0x01000008, be 4'b1111, wdata 0xDEADBEEF; one `done_o` pulse the cycle after gnt; `stall_o` low in that cycle.
- LB addr 0x01000003, rdata 0x80AA5511 -> `loaddata_o`=0xFFFFFF80. Same with LBU -> 0x00000080. Addr 0x01000001 LBU -> 0x00000055.
- LH addr 0x01000002, rdata 0x80011234 -> 0xFFFF8001. LHU -> 0x00008001. LH addr 0x01000000 -> 0x00001234.
- SH addr 0x01000002, storedata 0x0000ABCD -> wdata 0xABCDABCD, be 4'b1100. SB addr 0x01000001, data 0x77 -> be 4'b0010, wdata 0x77777777.
- LW addr 0x01000001 -> no `dmem_req_o` ever; `misalign_o` and `done_o` pulse together one cycle after accept; `stall_o` high only in the accept cycle; `loaddata_o` unchanged.
- LW issued, `rst` asserted in WAIT -> `dmem_req_o`/`stall_o` 0 asynchronously, `loaddata_o`=0. After release, a fresh LW addr 0x01000004 with rdata 0x12345678 -> `loaddata_o`=0x12345678 and `done_o` pulses once.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Memory stage: issues one load/store per accepted instruction over a req/gnt/rvalid
// handshake, aligns store lanes, extends load data and stalls upstream until done.
module dmem_access_unit #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] storedata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic [DWIDTH-1:0] loaddata_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic [3:0]        be;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q, req_d;
  logic              accept, bad;
  logic [DWIDTH-1:0] lb_sh, ld_ext;
  logic [15:0]       lh;

  assign accept = valid_i && (memren_i || memwren_i);

  // Request capture: lane replication, byte enables and legality check
  always_comb begin
    req_d.we     = memwren_i;
    req_d.funct3 = funct3_i;
    req_d.addr   = addr_i;
    req_d.wdata  = storedata_i;
    req_d.be     = 4'b1111;
    case (funct3_i[1:0])
      2'd0: begin
        req_d.wdata = {4{storedata_i[7:0]}};
        req_d.be    = 4'b0001 << addr_i[1:0];
      end
      2'd1: begin
        req_d.wdata = {2{storedata_i[15:0]}};
        req_d.be    = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (memwren_i) bad = (funct3_i >= 3'd3);
    else           bad = (funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11);
    if ((funct3_i[1:0] == 2'd1 && addr_i[0]) ||
        (funct3_i[1:0] == 2'd2 && addr_i[1:0] != 2'b00))
      bad = 1'b1;
  end

  // Load extraction from the lane selected by the latched address
  always_comb begin
    lb_sh = dmem_rdata_i >> {req_q.addr[1:0], 3'b000};
    lh    = req_q.addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (req_q.funct3)
      3'd0:    ld_ext = {{24{lb_sh[7]}}, lb_sh[7:0]};
      3'd4:    ld_ext = {24'd0, lb_sh[7:0]};
      3'd1:    ld_ext = {{16{lh[15]}}, lh};
      3'd5:    ld_ext = {16'd0, lh};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         req_q <= '0;
    else if (state == IDLE && accept) req_q <= req_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 loaddata_o <= '0;
    else if (state == WAIT && dmem_rvalid_i) loaddata_o <= ld_ext;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad ? ERR : REQ;
      REQ:     if (dmem_gnt_i) state_nxt = req_q.we ? RESP : WAIT;
      WAIT:    if (dmem_rvalid_i) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rst gates the IDLE stall so every output reads 0 while reset is held
  always_comb begin
    stall_o      = 1'b0;
    done_o       = 1'b0;
    misalign_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_be_o    = 4'b0000;
    case (state)
      IDLE: stall_o = accept && !rst;
      REQ: begin
        stall_o      = 1'b1;
        dmem_req_o   = 1'b1;
        dmem_we_o    = req_q.we;
        dmem_addr_o  = {req_q.addr[AWIDTH-1:2], 2'b00};
        dmem_wdata_o = req_q.wdata;
        dmem_be_o    = req_q.be;
      end
      WAIT: stall_o = 1'b1;
      RESP: done_o  = 1'b1;
      ERR: begin
        done_o     = 1'b1;
        misalign_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
